// File: rtl/mm_input_port_pkg.sv
// Shared definitions for the memory-mapped input port.
// Holds the address-map bases and register offsets.
package mm_input_port_pkg;

  localparam logic [3:0] IO_IN_BASE = 4'h2;
  localparam logic [3:0] LED_BASE   = 4'h1;

  typedef enum logic [1:0] {
    OFF_SW   = 2'd0,
    OFF_KEY  = 2'd1,
    OFF_EDGE = 2'd2,
    OFF_CNT  = 2'd3
  } io_off_e;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus tick-sampled debounce for one input group.
// A bit reaches db only after matching across two consecutive ticks.
module input_debounce #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  logic [W-1:0] sync1_q, sync2_q;
  logic [W-1:0] samp_q, samp_d;
  logic [W-1:0] db_q, db_d;
  logic [W-1:0] stable;

  assign stable = ~(sync2_q ^ samp_q);

  always_comb begin
    samp_d = samp_q;
    db_d   = db_q;
    if (tick) begin
      samp_d = sync2_q;
      db_d   = (sync2_q & stable) | (db_q & ~stable);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      samp_q  <= RST_VAL;
      db_q    <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/mm_input_port.sv
// Memory-mapped switch/key input port at 0x2000-0x2003.
// Debounced state, sticky press flags and a KEY[0] press counter.
module mm_input_port
  import mm_input_port_pkg::*;
#(
  parameter int DB_TICKS = 250000,
  parameter int SW_W     = 10,
  parameter int KEY_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic              W,
  input  logic [15:0]       din,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic [15:0]       dout,
  output logic              rd_sel
);

  localparam int TW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  logic [TW-1:0]    tick_q, tick_d;
  logic             tick;
  logic [SW_W-1:0]  sw_db;
  logic [KEY_W-1:0] key_db;
  logic [KEY_W-1:0] key_prev_q;
  logic [KEY_W-1:0] press;
  logic [KEY_W-1:0] clr;
  logic [KEY_W-1:0] edge_q, edge_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      rd_data;
  logic [15:0]      dout_q;
  logic             rd_sel_q;
  logic             sel;
  io_off_e          off;
  logic             wr_edge, wr_cnt;
  logic             unused_ok;

  assign unused_ok = ^{addr[11:2], din[15:KEY_W]};

  assign tick   = (tick_q == TW'(DB_TICKS - 1));
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  input_debounce #(
    .W       (SW_W),
    .RST_VAL ('0)
  ) u_sw_db (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .raw   (sw_in),
    .db    (sw_db)
  );

  input_debounce #(
    .W       (KEY_W),
    .RST_VAL ({KEY_W{1'b1}})
  ) u_key_db (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .raw   (key_in),
    .db    (key_db)
  );

  assign sel     = (addr[15:12] == IO_IN_BASE);
  assign off     = io_off_e'(addr[1:0]);
  assign wr_edge = sel & W & (off == OFF_EDGE);
  assign wr_cnt  = sel & W & (off == OFF_CNT);

  // Keys are active-low: a press is a 1->0 fall of the debounced level.
  assign press = key_prev_q & ~key_db;
  assign clr   = wr_edge ? din[KEY_W-1:0] : '0;

  always_comb begin
    edge_d = (edge_q & ~clr) | press;
    cnt_d  = wr_cnt ? 16'h0000 : cnt_q;
    if (press[0])
      cnt_d = cnt_d + 16'h0001;
  end

  always_comb begin
    rd_data = 16'h0000;
    unique case (off)
      OFF_SW:   rd_data = {{(16-SW_W){1'b0}}, sw_db};
      OFF_KEY:  rd_data = {{(16-KEY_W){1'b0}}, key_db};
      OFF_EDGE: rd_data = {{(16-KEY_W){1'b0}}, edge_q};
      OFF_CNT:  rd_data = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q     <= '0;
      key_prev_q <= '1;
      edge_q     <= '0;
      cnt_q      <= 16'h0000;
      dout_q     <= 16'h0000;
      rd_sel_q   <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      key_prev_q <= key_db;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      dout_q     <= sel ? rd_data : 16'h0000;
      rd_sel_q   <= sel;
    end
  end

  assign dout   = dout_q;
  assign rd_sel = rd_sel_q;

endmodule

// File: tb/tb_mm_input_port.sv
// Bench for mm_input_port with a short debounce period.
// Reads go through a scoreboard queue of expected {rd_sel, dout}.
module tb_mm_input_port;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        W;
  logic [15:0] din;
  logic [9:0]  sw_in;
  logic [2:0]  key_in;
  logic [15:0] dout;
  logic        rd_sel;

  mm_input_port #(
    .DB_TICKS (4),
    .SW_W     (10),
    .KEY_W    (3)
  ) dut (
    .clock  (clk),
    .reset  (reset),
    .addr   (addr),
    .W      (W),
    .din    (din),
    .sw_in  (sw_in),
    .key_in (key_in),
    .dout   (dout),
    .rd_sel (rd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        sel;
    logic [15:0] d;
  } vec_t;

  int          n_pass;
  int          n_total;
  logic [16:0] sb_q[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [16:0] act,
                     input logic [16:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic rd(input logic [15:0] a, input logic e_sel,
                    input logic [15:0] e_d, input string nm);
    logic [16:0] exp;
    addr = a;
    W    = 1'b0;
    sb_q.push_back({e_sel, e_d});
    step();
    exp = sb_q.pop_front();
    chk(nm, {rd_sel, dout}, exp);
    addr = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    W    = 1'b1;
    step();
    W    = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic press_key(input int k);
    key_in[k] = 1'b0;
    repeat (12) step();
    key_in[k] = 1'b1;
    repeat (12) step();
  endtask

  // Hold KEY[0] low and issue the write in the cycle the press is seen.
  task automatic press_with_write(input logic [15:0] a,
                                  input logic [15:0] d, input string nm);
    bit found;
    found = 1'b0;
    key_in[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dut.press[0]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (found) begin
      wr(a, d);
    end else begin
      n_total++;
      $display("FAIL %s: press not seen got 0 want 1", nm);
    end
    repeat (4) step();
    key_in[0] = 1'b1;
    repeat (12) step();
  endtask

  vec_t rst_vec[4];
  vec_t dec_vec[3];

  initial begin
    rst_vec[0] = '{16'h2000, 1'b1, 16'h0000};
    rst_vec[1] = '{16'h2001, 1'b1, 16'h0007};
    rst_vec[2] = '{16'h2002, 1'b1, 16'h0000};
    rst_vec[3] = '{16'h2003, 1'b1, 16'h0000};
    dec_vec[0] = '{16'h1000, 1'b0, 16'h0000};
    dec_vec[1] = '{16'h0005, 1'b0, 16'h0000};
    dec_vec[2] = '{16'h2FF6, 1'b1, 16'h0001};

    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    addr    = 16'h0000;
    W       = 1'b0;
    din     = 16'h0000;
    sw_in   = 10'h000;
    key_in  = 3'b111;
    repeat (3) step();
    chk("rst_rd_sel", {16'h0000, rd_sel}, 17'h0);
    chk("rst_dout", {1'b0, dout}, 17'h0);
    reset = 1'b0;
    step();

    foreach (rst_vec[i])
      rd(rst_vec[i].a, rst_vec[i].sel, rst_vec[i].d, "reset_regs");

    sw_in = 10'h2A5;
    repeat (12) step();
    rd(16'h2000, 1'b1, 16'h02A5, "sw_state");
    sw_in = 10'h000;
    step();
    sw_in = 10'h2A5;
    repeat (12) step();
    rd(16'h2000, 1'b1, 16'h02A5, "sw_glitch");

    press_key(1);
    rd(16'h2002, 1'b1, 16'h0002, "key1_edge");
    rd(16'h2001, 1'b1, 16'h0007, "key_released");
    wr(16'h2002, 16'h0002);
    rd(16'h2002, 1'b1, 16'h0000, "edge_w1c");

    repeat (5) press_key(0);
    rd(16'h2003, 1'b1, 16'h0005, "cnt_five");
    rd(16'h2002, 1'b1, 16'h0001, "key0_edge");

    force dut.cnt_q = 16'hFFFF;
    step();
    release dut.cnt_q;
    rd(16'h2003, 1'b1, 16'hFFFF, "cnt_preload");
    press_key(0);
    rd(16'h2003, 1'b1, 16'h0000, "cnt_wrap");
    press_key(0);
    rd(16'h2003, 1'b1, 16'h0001, "cnt_one");
    press_with_write(16'h2003, 16'h0000, "cnt_clr_inc");
    rd(16'h2003, 1'b1, 16'h0001, "cnt_clr_inc");

    wr(16'h2002, 16'h0007);
    rd(16'h2002, 1'b1, 16'h0000, "edge_clr_all");
    press_with_write(16'h2002, 16'h0001, "edge_set_wins");
    rd(16'h2002, 1'b1, 16'h0001, "edge_set_wins");
    rd(16'h2003, 1'b1, 16'h0002, "cnt_two");

    foreach (dec_vec[i])
      rd(dec_vec[i].a, dec_vec[i].sel, dec_vec[i].d, "decode");

    key_in[0] = 1'b0;
    sw_in     = 10'h3FF;
    repeat (5) step();
    reset  = 1'b1;
    addr   = 16'h2002;
    din    = 16'h0000;
    W      = 1'b1;
    key_in = 3'b111;
    sw_in  = 10'h000;
    repeat (2) step();
    W      = 1'b0;
    reset  = 1'b0;
    repeat (12) step();
    foreach (rst_vec[i])
      rd(rst_vec[i].a, rst_vec[i].sel, rst_vec[i].d, "mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
